fetch_seq_ctrl: RTL
===================

// Module: fetch_seq_ctrl
// PURPOSE
//   Fetch sequencer between the PC redirect sources and the icache port. Arbitrates redirects
//   (trap > branch > bpu > sequential), issues one icache request at a time with a valid/ready
//   handshake, discards stale responses after a redirect, and holds the fetched instruction
//   until the IF/ID stage accepts it. Single outstanding request.
// PARAMETERS
//   ADDR_W    64            PC / fetch address width
//   INST_W    32            instruction width returned by icache
//   RESET_PC  64'h80000000  first fetch address after reset
// PORTS
//   clk                 in   1       clock, rising edge
//   rst                 in   1       asynchronous reset, active high
//   trap_pc_i           in   ADDR_W  trap/CLINT target, from MEM
//   trap_valid_i        in   1       trap redirect, highest priority
//   branch_pc_i         in   ADDR_W  resolved branch target, from EXC
//   branch_valid_i      in   1       branch redirect
//   bpu_pc_i            in   ADDR_W  predicted target
//   bpu_valid_i         in   1       prediction redirect, lowest priority
//   icache_req_valid_o  out  1       fetch request valid
//   icache_req_addr_o   out  ADDR_W  fetch address
//   icache_req_ready_i  in   1       icache accepts request
//   icache_resp_valid_i in   1       response valid (1-cycle pulse)
//   icache_resp_inst_i  in   INST_W  fetched instruction
//   if_valid_o          out  1       instruction valid toward IF/ID
//   if_pc_o             out  ADDR_W  PC of if_inst_o
//   if_inst_o           out  INST_W  instruction
//   id_ready_i          in   1       IF/ID accepts (transfer = if_valid_o & id_ready_i)
// BEHAVIOUR
//   Reset (async): state=IDLE, fetch_pc=RESET_PC, pend_valid=0, kill=0; all outputs 0 except
//     icache_req_addr_o=RESET_PC.
//   redir = trap_valid_i|branch_valid_i|bpu_valid_i; redir_pc = highest-priority valid target.
//   FSM:
//     IDLE : 1 cycle after reset release -> REQ. A redirect here loads fetch_pc = redir_pc.
//     REQ  : req_valid=1, addr=fetch_pc. Addr/valid stable until ready. On valid&ready -> WAIT.
//            Redirect in REQ without ready: fetch_pc=redir_pc next cycle (REQ is not yet committed).
//            Redirect with ready same cycle: request issues, redir latched as pending, kill=1.
//     WAIT : Redirect -> pend_pc=redir_pc, pend_valid=1, kill=1 (later redirects overwrite).
//            On resp_valid: if kill|redir -> discard, fetch_pc=pend/redir pc, clear kill/pend, -> REQ;
//            else latch if_pc=fetch_pc, if_inst=resp, fetch_pc=next_pc(resp), -> HOLD.
//     HOLD : if_valid_o=1, outputs stable. Transfer -> REQ with fetch_pc already advanced.
//            Redirect (with or without id_ready) -> if_valid_o=0 next cycle, fetch_pc=redir_pc,
//            -> REQ; a same-cycle transfer is killed by the downstream flush that caused it.
//   next_pc = fetch_pc + 4, truncated to ADDR_W (wrap at 2^ADDR_W is silent).
//   Latency: resp_valid -> if_valid_o 1 cycle; transfer -> next req_valid 1 cycle.
//   resp_valid outside WAIT is ignored (protocol error, flagged by assertion in sim).
//   Same-cycle redirects: only the highest-priority source is used; others are dropped.
// CONFIGURATION
//   FETCH_SEQ_RVC_EN defined: next_pc = fetch_pc + 2 when resp_inst[1:0] != 2'b11, else +4.
//   FETCH_SEQ_RVC_EN undefined: next_pc always fetch_pc + 4; resp_inst[1:0] is not inspected.
// TESTING
//   Reset release, ready=1, resp 1 cycle later, id_ready=1 -> reqs at 80000000, 80000004, 80000008.
//   Ready held low 5 cycles in REQ -> addr/valid stable 5 cycles; ready high -> WAIT.
//   branch_valid(80001000) in WAIT -> that response dropped, if_valid_o stays 0, next req 80001000.
//   trap(80000100) + branch(80002000) same cycle in HOLD -> if_valid_o=0, next req 80000100.
//   id_ready=0 for 4 cycles in HOLD -> if_pc/if_inst unchanged, no new request issued.
//   FETCH_SEQ_RVC_EN, resp inst 16'h4501 at 80000000 -> next req 80000002; 32'h00000013 -> +4.

Source files
------------

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: redirect arbitration and single-outstanding icache fetch sequencing
// FETCH_SEQ_RVC_EN: step fetch_pc by 2 after a compressed (inst[1:0] != 2'b11) response.
module fetch_seq_ctrl #(
   parameter int                ADDR_W   = 64,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 64'h80000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] trap_pc_i,
   input  logic              trap_valid_i,
   input  logic [ADDR_W-1:0] branch_pc_i,
   input  logic              branch_valid_i,
   input  logic [ADDR_W-1:0] bpu_pc_i,
   input  logic              bpu_valid_i,
   output logic              icache_req_valid_o,
   output logic [ADDR_W-1:0] icache_req_addr_o,
   input  logic              icache_req_ready_i,
   input  logic              icache_resp_valid_i,
   input  logic [INST_W-1:0] icache_resp_inst_i,
   output logic              if_valid_o,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic [INST_W-1:0] if_inst_o,
   input  logic              id_ready_i
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
   state_t            r_state;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_pend_pc;
   logic              r_pend_valid;
   logic              r_kill;
   logic              r_req_valid;
   logic              r_if_valid;
   logic [ADDR_W-1:0] r_if_pc;
   logic [INST_W-1:0] r_if_inst;
   logic              w_redir;
   logic [ADDR_W-1:0] w_redir_pc;
   logic [ADDR_W-1:0] w_next_pc;
   assign w_redir    = trap_valid_i | branch_valid_i | bpu_valid_i;
   assign w_redir_pc = trap_valid_i ? trap_pc_i : branch_valid_i ? branch_pc_i : bpu_pc_i;
`ifdef FETCH_SEQ_RVC_EN
   assign w_next_pc  = r_fetch_pc + ((icache_resp_inst_i[1:0] != 2'b11) ? ADDR_W'(2) : ADDR_W'(4));
`else
   assign w_next_pc  = r_fetch_pc + ADDR_W'(4);
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_fetch_pc   <= RESET_PC;
         r_pend_pc    <= '0;
         r_pend_valid <= 1'b0;
         r_kill       <= 1'b0;
         r_req_valid  <= 1'b0;
         r_if_valid   <= 1'b0;
         r_if_pc      <= '0;
         r_if_inst    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_redir) r_fetch_pc <= w_redir_pc;
               r_state     <= REQ;
               r_req_valid <= 1'b1;
            end
            REQ: begin
               if (icache_req_ready_i) begin
                  r_state     <= WAIT;
                  r_req_valid <= 1'b0;
                  if (w_redir) begin
                     r_pend_pc    <= w_redir_pc;
                     r_pend_valid <= 1'b1;
                     r_kill       <= 1'b1;
                  end
               end else if (w_redir) begin
                  r_fetch_pc <= w_redir_pc;
               end
            end
            WAIT: begin
               if (icache_resp_valid_i) begin
                  r_kill       <= 1'b0;
                  r_pend_valid <= 1'b0;
                  // A flushed fetch returns straight to REQ at the newest redirect target
                  if (r_kill | w_redir) begin
                     r_state     <= REQ;
                     r_req_valid <= 1'b1;
                     r_fetch_pc  <= w_redir ? w_redir_pc : r_pend_valid ? r_pend_pc : r_fetch_pc;
                  end else begin
                     r_state    <= HOLD;
                     r_if_valid <= 1'b1;
                     r_if_pc    <= r_fetch_pc;
                     r_if_inst  <= icache_resp_inst_i;
                     r_fetch_pc <= w_next_pc;
                  end
               end else if (w_redir) begin
                  r_pend_pc    <= w_redir_pc;
                  r_pend_valid <= 1'b1;
                  r_kill       <= 1'b1;
               end
            end
            HOLD: begin
               if (w_redir | id_ready_i) begin
                  r_state     <= REQ;
                  r_req_valid <= 1'b1;
                  r_if_valid  <= 1'b0;
                  if (w_redir) r_fetch_pc <= w_redir_pc;
               end
            end
         endcase
      end
   end
   assign icache_req_valid_o = r_req_valid;
   assign icache_req_addr_o  = r_fetch_pc;
   assign if_valid_o         = r_if_valid;
   assign if_pc_o            = r_if_pc;
   assign if_inst_o          = r_if_inst;
   a_resp_in_wait: assert property (@(posedge clk) disable iff (rst) icache_resp_valid_i |-> r_state == WAIT);
endmodule
